// File: rtl/timer_pkg.sv
// Shared definitions for the 60-second timer: state encodings, digit limits
// and the terminal-count predicate used by the sequencer.
package timer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam logic [3:0] ONES_MAX = 4'd9;
  localparam logic [3:0] TENS_MAX = 4'd5;
  localparam int TICK_DIV_DEFAULT = 50000000;

  // Up-count stops at 59, down-count stops at 00.
  function automatic logic is_terminal(input logic dir, input logic [3:0] tens,
                                       input logic [3:0] ones);
    return (!dir && tens == TENS_MAX && ones == ONES_MAX) ||
           ( dir && tens == 4'd0     && ones == 4'd0);
  endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Divides the system clock down to a registered one-cycle Tick pulse.
// The count freezes while Enable is low so a paused run keeps its phase.
module tick_prescaler #(
  parameter int TICK_DIV = 50000000,
  parameter int TICK_W   = 26
) (
  input  logic Clock,
  input  logic Reset,
  input  logic Enable,
  input  logic Clear,
  output logic Tick
);

  localparam logic [TICK_W-1:0] LAST = TICK_W'(TICK_DIV - 1);

  logic [TICK_W-1:0] count_reg;
  logic              tick_reg;

  always_ff @(posedge Clock) begin
    if (Reset || Clear) begin
      count_reg <= '0;
      tick_reg  <= 1'b0;
    end else if (Enable) begin
      if (count_reg == LAST) begin
        count_reg <= '0;
        tick_reg  <= 1'b1;
      end else begin
        count_reg <= count_reg + TICK_W'(1);
        tick_reg  <= 1'b0;
      end
    end else begin
      tick_reg <= 1'b0;
    end
  end

  assign Tick = tick_reg;

endmodule

// File: rtl/timer_sequencer.sv
// Control FSM for the 60-second timer: turns button levels into run/pause/done
// states and drives hold, direction and reset controls of the digit counters.
module timer_sequencer
  import timer_pkg::*;
#(
  parameter int TICK_DIV = TICK_DIV_DEFAULT,
  parameter int TICK_W   = 26
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       Start,
  input  logic       Stop,
  input  logic       Clear,
  input  logic       Mode,
  input  logic [3:0] Ones,
  input  logic [3:0] Tens,
  output logic       HoldOnes,
  output logic       HoldTens,
  output logic       Direction,
  output logic       CntReset_n,
  output logic       Tick,
  output logic       Done,
  output logic       Alarm,
  output logic [1:0] State
);

  state_t state_reg, state_next;
  logic   dir_reg, dir_next;
  logic   alarm_reg, alarm_next;
  logic   cnt_rst_n_reg;
  logic   term;
  logic   adv;
  logic   presc_clear;

  assign term = is_terminal(dir_reg, Tens, Ones);

  always_comb begin
    state_next = state_reg;
    dir_next   = dir_reg;
    alarm_next = 1'b0;
    if (Clear) begin
      state_next = ST_IDLE;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (Start && !Stop) begin
            state_next = ST_RUN;
            dir_next   = Mode;
          end
        end
        ST_RUN: begin
          if (Stop) begin
            state_next = ST_PAUSE;
          end else if (term) begin
            state_next = ST_DONE;
            alarm_next = 1'b1;
          end
        end
        ST_PAUSE: begin
          if (Start && !Stop) state_next = ST_RUN;
        end
        ST_DONE: state_next = ST_DONE;
        default: state_next = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_reg     <= ST_IDLE;
      dir_reg       <= 1'b0;
      alarm_reg     <= 1'b0;
      cnt_rst_n_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      dir_reg       <= dir_next;
      alarm_reg     <= alarm_next;
      cnt_rst_n_reg <= !Clear;
    end
  end

  // Phase is dropped whenever a run ends; PAUSE simply stops the count.
  assign presc_clear = Clear ||
                       (state_next == ST_IDLE && state_reg != ST_IDLE) ||
                       (state_next == ST_DONE && state_reg != ST_DONE);

  tick_prescaler #(
    .TICK_DIV(TICK_DIV),
    .TICK_W  (TICK_W)
  ) u_prescaler (
    .Clock (Clock),
    .Reset (Reset),
    .Enable(state_reg == ST_RUN),
    .Clear (presc_clear),
    .Tick  (Tick)
  );

  // Counters advance on the edge where Tick is high; never past terminal count.
  assign adv      = !Reset && (state_reg == ST_RUN) && Tick && !term;
  assign HoldOnes = !adv;
  assign HoldTens = !(adv && ((!dir_reg && Ones == ONES_MAX) ||
                              ( dir_reg && Ones == 4'd0)));

  assign Direction  = dir_reg;
  assign CntReset_n = cnt_rst_n_reg;
  assign Alarm      = alarm_reg;
  assign Done       = (state_reg == ST_DONE);
  assign State      = state_reg;

endmodule

// File: tb/tb_timer_sequencer.sv
// Directed self-checking bench for timer_sequencer with a 4-cycle tick.
module tb_timer_sequencer;

  logic       Clock;
  logic       Reset;
  logic       Start;
  logic       Stop;
  logic       Clear;
  logic       Mode;
  logic [3:0] Ones;
  logic [3:0] Tens;
  logic       HoldOnes;
  logic       HoldTens;
  logic       Direction;
  logic       CntReset_n;
  logic       Tick;
  logic       Done;
  logic       Alarm;
  logic [1:0] State;

  int n_compared   = 0;
  int n_mismatched = 0;

  timer_sequencer #(
    .TICK_DIV(4),
    .TICK_W  (3)
  ) dut (
    .Clock     (Clock),
    .Reset     (Reset),
    .Start     (Start),
    .Stop      (Stop),
    .Clear     (Clear),
    .Mode      (Mode),
    .Ones      (Ones),
    .Tens      (Tens),
    .HoldOnes  (HoldOnes),
    .HoldTens  (HoldTens),
    .Direction (Direction),
    .CntReset_n(CntReset_n),
    .Tick      (Tick),
    .Done      (Done),
    .Alarm     (Alarm),
    .State     (State)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_compared++;
    if (got !== exp) begin
      n_mismatched++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end else begin
      $display("ok   %s: %0d (t=%0t)", tag, got, $time);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) @(posedge Clock);
    #1;
  endtask

  logic exp_tick;

  initial begin
    Reset = 1'b1; Start = 1'b0; Stop = 1'b0; Clear = 1'b0;
    Mode = 1'b0; Tens = 4'd0; Ones = 4'd0;

    // Reset held two cycles
    for (int i = 0; i < 2; i++) begin
      step();
      check_val("rst_state", State, 0);
      check_val("rst_hold_ones", HoldOnes, 1);
      check_val("rst_hold_tens", HoldTens, 1);
      check_val("rst_cntrst_n", CntReset_n, 0);
      check_val("rst_tick", Tick, 0);
      check_val("rst_done", Done, 0);
      check_val("rst_alarm", Alarm, 0);
      check_val("rst_dir", Direction, 0);
    end
    Reset = 1'b0;
    step();
    check_val("rel_cntrst_n", CntReset_n, 1);
    check_val("rel_state", State, 0);
    for (int i = 0; i < 3; i++) begin
      step();
      check_val("idle_tick", Tick, 0);
      check_val("idle_hold_ones", HoldOnes, 1);
    end

    // Count down from 30: tick every 4th cycle, tens borrows at ones==0
    Mode = 1'b1; Tens = 4'd3; Ones = 4'd0; Start = 1'b1;
    step();
    Start = 1'b0;
    check_val("go_state", State, 1);
    check_val("go_dir", Direction, 1);
    check_val("go_tick", Tick, 0);
    for (int i = 1; i <= 8; i++) begin
      step();
      exp_tick = (i % 4 == 0);
      check_val("run_tick", Tick, exp_tick);
      check_val("run_hold_ones", HoldOnes, !exp_tick);
      check_val("run_hold_tens", HoldTens, !(exp_tick && Ones == 4'd0));
      if (i == 4) begin
        Ones = 4'd5;
        #1;
        check_val("run_hold_tens_noborrow", HoldTens, 1);
        check_val("run_hold_ones_noborrow", HoldOnes, 0);
      end
    end

    // Pause two cycles into an interval, resume keeps phase
    step();
    check_val("pre_stop_tick1", Tick, 0);
    step();
    check_val("pre_stop_tick2", Tick, 0);
    Stop = 1'b1; Mode = 1'b0;
    step();
    Stop = 1'b0;
    check_val("pause_state", State, 2);
    for (int i = 0; i < 10; i++) begin
      step();
      check_val("pause_state_hold", State, 2);
      check_val("pause_tick", Tick, 0);
      check_val("pause_dir", Direction, 1);
    end
    Start = 1'b1;
    step();
    Start = 1'b0;
    check_val("resume_state", State, 1);
    check_val("resume_tick0", Tick, 0);
    check_val("resume_dir", Direction, 1);
    step();
    check_val("resume_tick1", Tick, 1);

    // Clear from RUN, then count up into terminal 59
    Clear = 1'b1;
    step();
    Clear = 1'b0;
    check_val("clr_run_state", State, 0);
    check_val("clr_run_cntrst_n", CntReset_n, 0);
    step();
    check_val("clr_run_cntrst_n_back", CntReset_n, 1);
    Mode = 1'b0; Tens = 4'd0; Ones = 4'd0; Start = 1'b1;
    step();
    Start = 1'b0;
    check_val("up_state", State, 1);
    check_val("up_dir", Direction, 0);
    for (int i = 0; i < 3; i++) begin
      step();
      check_val("up_tick_low", Tick, 0);
    end
    step();
    check_val("up_tick", Tick, 1);
    check_val("up_hold_ones_adv", HoldOnes, 0);
    Tens = 4'd5; Ones = 4'd9;
    #1;
    check_val("term_tick_still", Tick, 1);
    check_val("term_hold_ones", HoldOnes, 1);
    check_val("term_hold_tens", HoldTens, 1);
    step();
    check_val("done_state", State, 3);
    check_val("done_flag", Done, 1);
    check_val("done_alarm", Alarm, 1);
    check_val("done_tick", Tick, 0);
    step();
    check_val("done_alarm_drop", Alarm, 0);
    check_val("done_flag_hold", Done, 1);
    Start = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step();
      check_val("done_ignore_start", State, 3);
      check_val("done_ignore_alarm", Alarm, 0);
    end
    Start = 1'b0;

    // Clear pulse in DONE, then Clear held for 3 cycles
    Clear = 1'b1;
    step();
    Clear = 1'b0;
    check_val("clr_done_state", State, 0);
    check_val("clr_done_flag", Done, 0);
    check_val("clr_done_cntrst_n", CntReset_n, 0);
    step();
    check_val("clr_done_cntrst_n_back", CntReset_n, 1);
    Clear = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check_val("clr_held_cntrst_n", CntReset_n, 0);
    end
    Clear = 1'b0;
    step();
    check_val("clr_held_cntrst_n_back", CntReset_n, 1);

    // Start with digits already at terminal: one RUN cycle then DONE
    Start = 1'b1;
    step();
    Start = 1'b0;
    check_val("term_start_run", State, 1);
    step();
    check_val("term_start_done", State, 3);
    check_val("term_start_alarm", Alarm, 1);
    Clear = 1'b1;
    step();
    Clear = 1'b0;
    check_val("term_clr_state", State, 0);
    step();

    // Start+Stop in RUN -> PAUSE; stays PAUSE; Clear wins over both
    Tens = 4'd2; Ones = 4'd3; Start = 1'b1;
    step();
    check_val("both_run", State, 1);
    Stop = 1'b1;
    step();
    check_val("both_pause", State, 2);
    step();
    check_val("both_pause_stay", State, 2);
    Clear = 1'b1;
    step();
    check_val("all_clr_state", State, 0);
    check_val("all_clr_cntrst_n", CntReset_n, 0);
    Clear = 1'b0; Start = 1'b0; Stop = 1'b0;
    step();
    check_val("all_clr_cntrst_n_back", CntReset_n, 1);
    check_val("all_clr_idle", State, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule

// File: doc/timer_sequencer.md
Name: timer_sequencer

Overview:
- Control block for the 60-second timer datapath.
- Generates the 1 Hz advance tick from the system clock, runs the IDLE/RUN/PAUSE/DONE state machine from the user buttons, and drives the Hold/Direction/reset controls of the ones (mod-10) and tens (mod-6) digit counters.
- Watches the digit values to stop at terminal count and raise Done/Alarm.
- Sits between the debounced button inputs and the digit counters; it contains no digit storage of its own.

Parameters:
- TICK_DIV, 50000000, Clock cycles per tick; minimum 2; benches use 4.
- TICK_W, 26, prescaler width; must satisfy 2^TICK_W >= TICK_DIV.

Ports:
- Clock  in  1  system clock; all state updates on the rising edge.
- Reset  in  1  synchronous, active-high reset.
- Start  in  1  level; start or resume counting.
- Stop  in  1  level; pause counting.
- Clear  in  1  level; reload the counters and return to IDLE.
- Mode  in  1  0 = count up, 1 = count down; sampled only on IDLE->RUN.
- Ones  in  4  current ones digit (0-9).
- Tens  in  4  current tens digit (0-5).
- HoldOnes  out  1  1 = ones counter holds this cycle.
- HoldTens  out  1  1 = tens counter holds this cycle.
- Direction  out  1  registered copy of the latched Mode, to both counters.
- CntReset_n  out  1  active-low reset to both counters, registered.
- Tick  out  1  registered one-cycle pulse, once per TICK_DIV cycles while in RUN.
- Done  out  1  high while in DONE.
- Alarm  out  1  one-cycle pulse on entry to DONE.
- State  out  2  IDLE=0, RUN=1, PAUSE=2, DONE=3.

Behaviour:
- Reset (sampled high):
  - Next state: State=IDLE, prescaler=0, Tick=0, Direction=0, Done=0, Alarm=0, CntReset_n=0.
  - CntReset_n returns to 1 on the first edge where Reset is low.
  - HoldOnes and HoldTens are 1 throughout reset.
- Command priority per cycle: Reset > Clear > Stop > Start.
- Terminal condition (combinational):
  - TERM = (Direction==0 && Tens==5 && Ones==9) || (Direction==1 && Tens==0 && Ones==0).
- State transitions:
  - IDLE: Start -> RUN; Direction <= Mode in that same edge. Otherwise stay.
  - RUN:
    - Clear -> IDLE.
    - Else Stop -> PAUSE.
    - Else TERM -> DONE, with Alarm=1 for exactly one cycle.
    - Else stay.
  - PAUSE: Clear -> IDLE; else Start (with Stop low) -> RUN; else stay. The prescaler holds its value (resume keeps the phase).
  - DONE: Clear -> IDLE; Start and Stop are ignored.
- Clear, in any state: CntReset_n=0 for exactly one cycle (the cycle after Clear is sampled); prescaler <= 0. If Clear is held, CntReset_n stays 0.
- Prescaler:
  - Counts only in RUN.
  - When prescaler==TICK_DIV-1: wraps to 0 and Tick=1 next cycle; otherwise Tick=0.
  - Cleared on entering IDLE or DONE.
- Hold outputs (combinational from registered state, Tick and inputs):
  - ADV = (State==RUN) && Tick && !TERM.
  - HoldOnes = !ADV.
  - HoldTens = !(ADV && ((Direction==0 && Ones==9) || (Direction==1 && Ones==0))).
  - The counters therefore advance on the same edge on which Tick is high, so there is no extra latency.
- A Tick arriving while TERM is true never advances the counters.
- Start with the digits already at TERM: IDLE->RUN, then DONE on the next edge.
- Stop and Start both high in RUN gives PAUSE; in PAUSE the pair stays in PAUSE.
- Mode changes outside IDLE->RUN have no effect.
- The Tens and Ones inputs are trusted; out-of-range values never make TERM true except as listed above.

Decomposition:
- Shared package timer_pkg holds:
  - State encodings ST_IDLE/ST_RUN/ST_PAUSE/ST_DONE.
  - Digit limits ONES_MAX=9 and TENS_MAX=5.
  - Default TICK_DIV.
- One sub-module: tick_prescaler, with inputs Clock, Reset, Enable, Clear, output Tick, parameters TICK_DIV and TICK_W.
- The FSM, terminal detection and hold logic stay in timer_sequencer.

Test Plan (TICK_DIV=4):
- Reset held 2 cycles, then released -> State=0, HoldOnes=HoldTens=1, CntReset_n=0 during reset and 1 on the first cycle after; Tick never pulses.
- Mode=1, Tens=3, Ones=0, one-cycle Start pulse -> State=1, Direction=1; Tick every 4th cycle; on the first Tick, HoldOnes=0 and HoldTens=0 (tens borrows).
- Stop pulse 2 cycles into a RUN interval, wait 10 cycles, then Start -> State=2 with no Tick while paused; after resume, the first Tick arrives 2 cycles later (phase kept).
- Mode=0 in RUN, inputs driven to Tens=5, Ones=9 -> next edge State=3, Done=1, Alarm high for exactly 1 cycle; HoldOnes=HoldTens=1 even when Tick=1; further Start pulses are ignored.
- Clear pulse in DONE -> CntReset_n low for exactly 1 cycle, State=0, Done=0; Clear held 3 cycles -> CntReset_n low for 3 cycles.
- Start and Stop high together in RUN -> State=2; Clear, Stop and Start together -> State=0 with a CntReset_n pulse.
